// File: rtl/gr_heep_arb_pkg.sv
// Shared types and helpers for the GR-HEEP OBI N-to-1 arbiter.
// Holds OBI bundles, arbiter state encoding and the round-robin pick.
package gr_heep_arb_pkg;

  localparam int GrantCntW = 16;
  localparam int MaxMaster = 16;
  localparam int MaxIdxW   = 4;

  typedef enum logic {
    IDLE_OR_FREE,
    LOCKED
  } arb_state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Returns {found, idx}: first set bit of req_vec at or after
  // ptr, wrapping at n.
  function automatic logic [MaxIdxW:0] rr_pick(
    input logic [MaxMaster-1:0] req_vec,
    input int                   ptr,
    input int                   n
  );
    logic               found;
    logic [MaxIdxW-1:0] idx;
    int                 c;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < MaxMaster; k++) begin
      c = ptr + k;
      if (c >= n) c = c - n;
      if (k < n && !found &&
          req_vec[c[MaxIdxW-1:0]]) begin
        found = 1'b1;
        idx   = c[MaxIdxW-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/gr_heep_arb_idx_fifo.sv
// In-order FIFO of granted master indices awaiting a response.
// Ports: push_i/data_i, pop_i/data_o (head), full_o, empty_o, count_o.
module gr_heep_arb_idx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2,
  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic            pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] nxt(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_o == CntW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign data_o  = mem[rd_ptr];
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves
  // in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CntW'(1);
        2'b01:   count_o <= count_o - CntW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/gr_heep_obi_rr_arbiter.sv
// Round-robin N-to-1 OBI arbiter with in-order response routing.
// Ports: clk_i, rst_i, master_req_i/master_resp_o[N],
//   slave_req_o/slave_resp_i, busy_o, err_o, and grant_cnt_o
//   only when GR_HEEP_OBI_ARB_PERF_EN is defined.
module gr_heep_obi_rr_arbiter
  import gr_heep_arb_pkg::*;
#(
  parameter int NUM_MASTER      = 3,
  parameter int MAX_OUTSTANDING = 2,
  localparam int IdxW = $clog2(NUM_MASTER),
  localparam int CntW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  obi_req_t  [NUM_MASTER-1:0] master_req_i,
  output obi_resp_t [NUM_MASTER-1:0] master_resp_o,
  output obi_req_t                  slave_req_o,
  input  obi_resp_t                 slave_resp_i,
  output logic                      busy_o,
  output logic                      err_o
`ifdef GR_HEEP_OBI_ARB_PERF_EN
  ,
  output logic [NUM_MASTER-1:0][GrantCntW-1:0] grant_cnt_o
`endif
);

  arb_state_t         state;
  logic [IdxW-1:0]    lock_idx;
  logic [IdxW-1:0]    rr_ptr;
  logic [IdxW-1:0]    win;
  logic               win_req;
  logic               hs;
  logic               rv_ok;
  logic [MaxMaster-1:0] req_vec;
  logic [MaxIdxW:0]   pick;
  logic [IdxW-1:0]    head;
  logic               full;
  logic               empty;
  logic [CntW-1:0]    count;

  gr_heep_arb_idx_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IdxW)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (win),
    .pop_i   (rv_ok),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_MASTER; i++)
      req_vec[i] = master_req_i[i].req;
    pick = rr_pick(req_vec, int'(rr_ptr), NUM_MASTER);
    // A stalled request stays with its master until gnt,
    // regardless of priority or outstanding-limit changes.
    if (state == LOCKED) begin
      win     = lock_idx;
      win_req = master_req_i[lock_idx].req;
    end else begin
      win     = IdxW'(pick[MaxIdxW-1:0]);
      win_req = pick[MaxIdxW] & ~full;
    end
    win_req = win_req & ~rst_i;
  end

  always_comb begin
    slave_req_o = '0;
    if (win_req) begin
      slave_req_o     = master_req_i[win];
      slave_req_o.req = 1'b1;
    end
  end

  assign hs     = win_req & slave_resp_i.gnt;
  assign rv_ok  = slave_resp_i.rvalid & ~empty & ~rst_i;
  assign busy_o = (count != '0) | slave_req_o.req;

  always_comb begin
    master_resp_o = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      master_resp_o[i].gnt = hs & (win == IdxW'(i));
      if (rv_ok && head == IdxW'(i)) begin
        master_resp_o[i].rvalid = 1'b1;
        master_resp_o[i].rdata  = slave_resp_i.rdata;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE_OR_FREE;
      lock_idx <= '0;
      rr_ptr   <= '0;
      err_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE_OR_FREE: begin
          if (win_req && !slave_resp_i.gnt) begin
            state    <= LOCKED;
            lock_idx <= win;
          end
        end
        LOCKED: begin
          if (slave_resp_i.gnt) state <= IDLE_OR_FREE;
        end
        default: state <= IDLE_OR_FREE;
      endcase
      if (hs) begin
        rr_ptr <= (win == IdxW'(NUM_MASTER - 1)) ?
                  '0 : win + IdxW'(1);
      end
      if (slave_resp_i.rvalid && empty) err_o <= 1'b1;
    end
  end

`ifdef GR_HEEP_OBI_ARB_PERF_EN
  for (genvar g = 0; g < NUM_MASTER; g++) begin : g_cnt
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        grant_cnt_o[g] <= '0;
      end else if (hs && win == IdxW'(g) &&
                   grant_cnt_o[g] != '1) begin
        grant_cnt_o[g] <= grant_cnt_o[g] + GrantCntW'(1);
      end
    end
  end
`endif

endmodule
